// File: rtl/i2c_reg_seq_pkg.sv
// Shared definitions for the i2c register-access sequencer: i2c_master command/status
// encodings, step-list indices, FSM state types and the step builder.
package i2c_reg_seq_pkg;

  localparam int C_SZ = 6;
  localparam int S_SZ = 2;

  // Command bits; START/STOP/NACK ride along with WRTE/READ in one command word.
  localparam logic [C_SZ-1:0] C_STRT = 6'h01;
  localparam logic [C_SZ-1:0] C_STOP = 6'h02;
  localparam logic [C_SZ-1:0] C_WRTE = 6'h04;
  localparam logic [C_SZ-1:0] C_READ = 6'h08;
  localparam logic [C_SZ-1:0] C_NACK = 6'h10;
  localparam logic [C_SZ-1:0] C_CLRS = 6'h20;

  // Status bit positions within mst_stat.
  localparam int SB_BSY = 0;
  localparam int SB_ERR = 1;

  localparam int MAX_LEN_DEF = 4;
  localparam int BSY_TO_DEF  = 4;

  // Step-list positions. STP_MID is the write data phase or the read re-address.
  localparam logic [2:0] STP_ADDR = 3'd0;
  localparam logic [2:0] STP_REG  = 3'd1;
  localparam logic [2:0] STP_MID  = 3'd2;
  localparam logic [2:0] STP_RDAT = 3'd3;
  localparam logic [2:0] STP_STOP = 3'd4;

  typedef struct packed {
    logic [C_SZ-1:0] cmd;
    logic [7:0]      dat;
  } step_t;

  typedef enum logic [2:0] {
    ISS_IDLE,
    ISS_SETUP,
    ISS_STROBE,
    ISS_WAIT_HI,
    ISS_WAIT_LO,
    ISS_CHECK
  } iss_state_e;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_CLR,
    SEQ_CLR_WAIT,
    SEQ_RSTOP,
    SEQ_RSTOP_WAIT,
    SEQ_FIN
  } seq_state_e;

  // Command/data for the current position in the write or read step list.
  function automatic step_t build_step(
    input logic        rnw,
    input logic [2:0]  step_idx,
    input logic [1:0]  byte_idx,
    input logic [1:0]  len,
    input logic [6:0]  dev,
    input logic [7:0]  reg_idx,
    input logic [31:0] wdata
  );
    step_t       s;
    logic [31:0] wsh;
    logic        last;
    s    = '{cmd: C_STOP, dat: 8'h00};
    wsh  = wdata << {byte_idx, 3'b000};
    last = (byte_idx == len);
    case (step_idx)
      STP_ADDR: s = '{cmd: C_STRT | C_WRTE, dat: {dev, 1'b0}};
      STP_REG:  s = '{cmd: C_WRTE, dat: reg_idx};
      STP_MID: begin
        if (rnw) s = '{cmd: C_STRT | C_WRTE, dat: {dev, 1'b1}};
        else     s = '{cmd: last ? (C_WRTE | C_STOP) : C_WRTE, dat: wsh[31:24]};
      end
      STP_RDAT: s = '{cmd: last ? (C_READ | C_NACK) : C_READ, dat: 8'h00};
      default:  s = '{cmd: C_STOP, dat: 8'h00};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/i2c_reg_seq_step_issuer.sv
// Runs one i2c_master command step: present cmd/dat, strobe ws once, follow BSY/ERR,
// and report step_done/step_err. Clear-status steps skip the busy handshake.
module i2c_step_issuer
  import i2c_reg_seq_pkg::*;
#(
  parameter int BSY_TO = BSY_TO_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clr,
  input  step_t           step,
  output logic [C_SZ-1:0] mst_cmd,
  output logic [7:0]      mst_dat,
  output logic            mst_ws,
  input  logic [S_SZ-1:0] mst_stat,
  output logic            step_done,
  output logic            step_err
);

  localparam int TW = $clog2(BSY_TO + 1);

  iss_state_e state, state_nx;
  logic       clr_q;
  logic [TW-1:0] to_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ISS_IDLE;
      mst_cmd <= '0;
      mst_dat <= '0;
      clr_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state <= state_nx;
      // cmd/dat load one cycle ahead of the strobe and hold until the next step.
      if (state == ISS_IDLE && start) begin
        mst_cmd <= step.cmd;
        mst_dat <= step.dat;
        clr_q   <= clr;
      end
      if (state == ISS_WAIT_HI) to_cnt <= to_cnt + 1'b1;
      else                      to_cnt <= '0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    mst_ws    = 1'b0;
    step_done = 1'b0;
    step_err  = 1'b0;
    case (state)
      ISS_IDLE:   if (start) state_nx = ISS_SETUP;
      ISS_SETUP:  state_nx = ISS_STROBE;
      ISS_STROBE: begin
        mst_ws   = 1'b1;
        state_nx = clr_q ? ISS_CHECK : ISS_WAIT_HI;
      end
      ISS_WAIT_HI: begin
        // ERR wins even with BSY still high; a master that never raises BSY times out.
        if (mst_stat[SB_ERR])                 state_nx = ISS_CHECK;
        else if (mst_stat[SB_BSY])            state_nx = ISS_WAIT_LO;
        else if (to_cnt == TW'(BSY_TO - 1))   state_nx = ISS_CHECK;
      end
      ISS_WAIT_LO: if (!mst_stat[SB_BSY]) state_nx = ISS_CHECK;
      ISS_CHECK: begin
        step_done = 1'b1;
        step_err  = mst_stat[SB_ERR] & ~clr_q;
        state_nx  = ISS_IDLE;
      end
      default: state_nx = ISS_IDLE;
    endcase
  end

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer: expands one host read/write request into i2c_master
// command steps, packs read data, and recovers the bus with CLRS + STOP after errors.
module i2c_reg_seq
  import i2c_reg_seq_pkg::*;
#(
  parameter int BSY_TO  = BSY_TO_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 rnw,
  input  logic [6:0]           dev,
  input  logic [7:0]           reg_idx,
  input  logic [1:0]           len,
  input  logic [8*MAX_LEN-1:0] wdata,
  output logic [8*MAX_LEN-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [C_SZ-1:0]      mst_cmd,
  output logic [7:0]           mst_dat,
  output logic                 mst_ws,
  input  logic [S_SZ-1:0]      mst_stat,
  input  logic [7:0]           mst_rdat
);

  seq_state_e state, state_nx;

  logic                 rnw_q;
  logic [6:0]           dev_q;
  logic [7:0]           reg_q;
  logic [1:0]           len_q;
  logic [8*MAX_LEN-1:0] wdata_q;
  logic [2:0]           step_idx;
  logic [1:0]           byte_idx;
  logic                 final_clr;

  step_t cur_step, iss_step;
  logic  iss_start, iss_clr;
  logic  step_done, step_err;
  logic  rd_step, data_step, last_step;
  logic [8*MAX_LEN-1:0] rd_byte_sh;

  assign cur_step  = build_step(rnw_q, step_idx, byte_idx, len_q, dev_q, reg_q, wdata_q);
  assign rd_step   = rnw_q && (step_idx == STP_RDAT);
  assign data_step = rnw_q ? rd_step : (step_idx == STP_MID);
  assign last_step = rnw_q ? (step_idx == STP_STOP)
                           : ((step_idx == STP_MID) && (byte_idx == len_q));
  // Byte k lands MSB-first: byte 0 at the top of rdata.
  assign rd_byte_sh = {{(8*MAX_LEN-8){1'b0}}, mst_rdat} << {~byte_idx, 3'b000};

  i2c_step_issuer #(.BSY_TO(BSY_TO)) u_issuer (
    .clk       (clk),
    .rst       (rst),
    .start     (iss_start),
    .clr       (iss_clr),
    .step      (iss_step),
    .mst_cmd   (mst_cmd),
    .mst_dat   (mst_dat),
    .mst_ws    (mst_ws),
    .mst_stat  (mst_stat),
    .step_done (step_done),
    .step_err  (step_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEQ_IDLE;
      rnw_q     <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      step_idx  <= '0;
      byte_idx  <= '0;
      final_clr <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        SEQ_IDLE: if (req) begin
          rnw_q     <= rnw;
          dev_q     <= dev;
          reg_q     <= reg_idx;
          len_q     <= len;
          wdata_q   <= wdata;
          step_idx  <= STP_ADDR;
          byte_idx  <= '0;
          final_clr <= 1'b0;
          rdata     <= '0;
          err       <= 1'b0;
        end
        SEQ_WAIT: if (step_done) begin
          if (step_err) begin
            err <= 1'b1;
          end else begin
            if (rd_step) rdata <= rdata | rd_byte_sh;
            if (data_step && byte_idx != len_q) byte_idx <= byte_idx + 1'b1;
            else if (!last_step)                step_idx <= step_idx + 1'b1;
          end
        end
        // A failed recovery STOP gets exactly one more CLRS, then the transfer ends.
        SEQ_RSTOP_WAIT: if (step_done && step_err) begin
          err       <= 1'b1;
          final_clr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    iss_start = 1'b0;
    iss_clr   = 1'b0;
    iss_step  = cur_step;
    done      = 1'b0;
    busy      = (state != SEQ_IDLE) && (state != SEQ_FIN);
    case (state)
      SEQ_IDLE:  if (req) state_nx = SEQ_ISSUE;
      SEQ_ISSUE: begin
        iss_start = 1'b1;
        state_nx  = SEQ_WAIT;
      end
      SEQ_WAIT: if (step_done) begin
        if (step_err)       state_nx = SEQ_CLR;
        else if (last_step) state_nx = SEQ_FIN;
        else                state_nx = SEQ_ISSUE;
      end
      SEQ_CLR: begin
        iss_start = 1'b1;
        iss_clr   = 1'b1;
        iss_step  = '{cmd: C_CLRS, dat: 8'h00};
        state_nx  = SEQ_CLR_WAIT;
      end
      SEQ_CLR_WAIT: if (step_done) state_nx = final_clr ? SEQ_FIN : SEQ_RSTOP;
      SEQ_RSTOP: begin
        iss_start = 1'b1;
        iss_step  = '{cmd: C_STOP, dat: 8'h00};
        state_nx  = SEQ_RSTOP_WAIT;
      end
      SEQ_RSTOP_WAIT: if (step_done) state_nx = step_err ? SEQ_CLR : SEQ_FIN;
      SEQ_FIN: begin
        done     = 1'b1;
        state_nx = SEQ_IDLE;
      end
      default: state_nx = SEQ_IDLE;
    endcase
  end

endmodule
